// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue sequencer: owns the PC, reads program ROM, splits each word into
// decoder fields and resolves the next PC (jumps, BSR/RET through a small return stack).
module fetch_sequencer #(
    parameter int ADDR_W      = 13,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [17:0]       rom_data,
    output logic [7:0]        OPCODE,
    output logic [4:0]        Ri,
    output logic [4:0]        Rj,
    output logic [7:0]        K,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic              flag_z,
    input  logic              flag_n,
    input  logic              flag_cy,
    output logic [ADDR_W-1:0] pc,
    output logic              fault
);

    // state   | meaning
    // S_FETCH | drive ROM address/strobe (waits one cycle after reset release)
    // S_WAIT  | ROM data valid; latch fields into decoder registers
    // S_ISSUE | instruction presented; resolve next PC on exec_done
    // S_FAULT | return-stack overflow/underflow; halted until reset

    localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
    localparam int IDX_W = SP_W - 1;

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_ISSUE, S_FAULT} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               armed;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  pc_nxt;
    logic [ADDR_W-1:0]  y_target;
    logic [ADDR_W-1:0]  bsr_target;
    logic [12:0]        y13;
    logic signed [11:0] bsr_off;
    logic [SP_W-1:0]    sp;
    logic [IDX_W-1:0]   top_idx;
    logic [ADDR_W-1:0]  stack [STACK_DEPTH];
    logic               is_jmp, is_jze, is_jne, is_jcy, is_bsr, is_ret;
    logic               stack_err;
    logic               retire;

    // Ri/Rj together are instruction word bits [9:0], so no separate copy of the word is kept
    always_comb begin
        is_jmp     = (OPCODE[7:3] == 5'b00100);
        is_jze     = (OPCODE[7:3] == 5'b00101);
        is_jne     = (OPCODE[7:3] == 5'b00110);
        is_jcy     = (OPCODE[7:3] == 5'b00111);
        is_bsr     = (OPCODE[7:2] == 6'b000111);
        is_ret     = (OPCODE == 8'h01);
        y13        = {OPCODE[2:0], Ri, Rj};
        y_target   = ADDR_W'(y13);
        bsr_off    = signed'({OPCODE[1:0], Ri, Rj});
        pc_inc     = pc_q + ADDR_W'(1);
        bsr_target = pc_inc + ADDR_W'(bsr_off);
        top_idx    = sp[IDX_W-1:0] - IDX_W'(1);
        stack_err  = (is_bsr && (sp == SP_W'(STACK_DEPTH))) || (is_ret && (sp == '0));
        retire     = (state == S_ISSUE) && exec_done;
    end

    always_comb begin
        pc_nxt = pc_inc;
        if (is_jmp)      pc_nxt = y_target;
        else if (is_jze) pc_nxt = flag_z  ? y_target : pc_inc;
        else if (is_jne) pc_nxt = !flag_n ? y_target : pc_inc;
        else if (is_jcy) pc_nxt = flag_cy ? y_target : pc_inc;
        else if (is_bsr) pc_nxt = bsr_target;
        else if (is_ret) pc_nxt = stack[top_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_FETCH: if (armed) state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_ISSUE;
            S_ISSUE: if (exec_done) state_nxt = stack_err ? S_FAULT : S_FETCH;
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        rom_rd   = (state == S_FETCH) && armed;
        rom_addr = pc_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed       <= 1'b0;
            pc_q        <= '0;
            sp          <= '0;
            OPCODE      <= '0;
            Ri          <= '0;
            Rj          <= '0;
            K           <= '0;
            instr_valid <= 1'b0;
            pc          <= '0;
            fault       <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
        end else begin
            armed <= 1'b1;
            if (state == S_WAIT) begin
                OPCODE      <= rom_data[17:10];
                Ri          <= rom_data[9:5];
                Rj          <= rom_data[4:0];
                K           <= rom_data[7:0];
                pc          <= pc_q;
                instr_valid <= 1'b1;
            end
            if (retire) begin
                instr_valid <= 1'b0;
                if (stack_err) begin
                    fault <= 1'b1;
                end else begin
                    pc_q <= pc_nxt;
                    if (is_bsr) begin
                        stack[sp[IDX_W-1:0]] <= pc_inc;
                        sp                   <= sp + SP_W'(1);
                    end
                    if (is_ret) sp <= sp - SP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a 1-cycle-latency ROM model preloaded per test and
// hand-computed fetch address sequences.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset_n;
    logic [12:0] rom_addr;
    logic        rom_rd;
    logic [17:0] rom_data;
    logic [7:0]  OPCODE;
    logic [4:0]  Ri;
    logic [4:0]  Rj;
    logic [7:0]  K;
    logic        instr_valid;
    logic        exec_done;
    logic        flag_z;
    logic        flag_n;
    logic        flag_cy;
    logic [12:0] pc;
    logic        fault;

    logic [17:0] rom [0:8191];
    logic [17:0] rom_q;
    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          fetch_cyc = 0;

    fetch_sequencer #(.ADDR_W(13), .STACK_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .rom_addr(rom_addr), .rom_rd(rom_rd),
        .rom_data(rom_data), .OPCODE(OPCODE), .Ri(Ri), .Rj(Rj), .K(K),
        .instr_valid(instr_valid), .exec_done(exec_done), .flag_z(flag_z),
        .flag_n(flag_n), .flag_cy(flag_cy), .pc(pc), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rom_rd) rom_q <= rom[rom_addr];
    end
    assign rom_data = rom_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_fetch(output logic [12:0] addr);
        int n;
        n = 0;
        @(negedge clk);
        while (rom_rd !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (rom_rd !== 1'b1) begin
            check("fetch_timeout", 0, 1);
            addr = '1;
        end else begin
            addr = rom_addr;
        end
        fetch_cyc = cyc;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic count_rd(input int cycles, output int hits);
        hits = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (rom_rd) hits++;
        end
    endtask

    logic [12:0] a;
    int          c0;
    int          hits;
    logic [7:0]  br_op  [6] = '{8'h28, 8'h28, 8'h30, 8'h30, 8'h38, 8'h38};
    logic [2:0]  br_flg [6] = '{3'b110, 3'b001, 3'b101, 3'b111, 3'b011, 3'b100};
    logic [12:0] br_exp [6] = '{13'h155, 13'h006, 13'h155, 13'h006, 13'h155, 13'h006};

    initial begin
        for (int i = 0; i < 8192; i++) rom[i] = '0;
        rom_q     = '0;
        reset_n   = 1'b1;
        exec_done = 1'b1;
        flag_z    = 1'b0;
        flag_n    = 1'b0;
        flag_cy   = 1'b0;

        // reset state
        #2 reset_n = 1'b0;
        #1;
        check("rst_rom_rd", rom_rd, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_fault", fault, 0);
        check("rst_fields", {OPCODE, Ri, Rj, K}, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_pc", pc, 0);

        // NOP stream, 3 cycles per instruction
        do_reset();
        next_fetch(a); check("nop_f0", a, 0); c0 = fetch_cyc;
        next_fetch(a); check("nop_f1", a, 1); check("nop_gap1", fetch_cyc - c0, 3);
        check("nop_pc1", pc, 0); check("nop_valid", instr_valid, 0); c0 = fetch_cyc;
        next_fetch(a); check("nop_f2", a, 2); check("nop_gap2", fetch_cyc - c0, 3);
        check("nop_pc2", pc, 1);

        // conditional jumps at PC 5, Y = 0x155; flags = {z, n, cy}
        for (int t = 0; t < 6; t++) begin
            rom[5] = {br_op[t], 10'h155};
            {flag_z, flag_n, flag_cy} = br_flg[t];
            do_reset();
            for (int k = 0; k < 6; k++) next_fetch(a);
            check("br_at5", a, 5);
            next_fetch(a);
            check($sformatf("br_target_%0d", t), a, br_exp[t]);
        end
        rom[5] = '0;
        {flag_z, flag_n, flag_cy} = 3'b000;

        // BSR at 0x10 with offset -4, RET at 0x0D
        rom[0]    = {8'h20, 10'h010};
        rom[13'h10] = {8'h1F, 10'h3FC};
        rom[13'h0D] = {8'h01, 10'h000};
        do_reset();
        next_fetch(a); check("bsr_f0", a, 0);
        next_fetch(a); check("bsr_f10", a, 13'h10);
        next_fetch(a); check("bsr_fD", a, 13'h0D);
        next_fetch(a); check("ret_f11", a, 13'h11);
        check("ret_pc", pc, 13'h0D);
        check("ret_fault", fault, 0);
        rom[13'h10] = '0;
        rom[13'h0D] = '0;

        // five nested BSRs overflow a 4-deep stack
        rom[0] = {8'h20, 10'h020};
        for (int i = 0; i < 5; i++) rom[13'h20 + i] = {8'h1C, 10'h000};
        do_reset();
        next_fetch(a); check("ovf_f0", a, 0);
        for (int i = 0; i < 5; i++) begin
            next_fetch(a);
            check($sformatf("ovf_f%0d", i), a, 13'h20 + i);
        end
        check("ovf_pre_fault", fault, 0);
        count_rd(10, hits);
        check("ovf_fault", fault, 1);
        check("ovf_no_rd", hits, 0);
        check("ovf_valid", instr_valid, 0);
        check("ovf_addr_frozen", rom_addr, 13'h24);
        for (int i = 0; i < 5; i++) rom[13'h20 + i] = '0;

        // RET with empty stack
        rom[0] = {8'h01, 10'h000};
        do_reset();
        #1 check("unf_fault_clr", fault, 0);
        next_fetch(a); check("unf_f0", a, 0);
        count_rd(6, hits);
        check("unf_fault", fault, 1);
        check("unf_no_rd", hits, 0);

        // exec_done held low in ISSUE; flags only sampled on the exec_done cycle
        rom[0] = '0;
        rom[1] = {8'h28, 10'h155};
        flag_z = 1'b1;
        do_reset();
        next_fetch(a); check("hold_f0", a, 0);
        next_fetch(a); check("hold_f1", a, 1);
        exec_done = 1'b0;
        repeat (2) @(negedge clk);
        hits = 0;
        for (int i = 0; i < 7; i++) begin
            check("hold_valid", instr_valid, 1);
            check("hold_fields", {OPCODE, Ri, Rj, K}, {8'h28, 5'h0A, 5'h15, 8'h55});
            check("hold_pc", pc, 1);
            if (rom_rd) hits++;
            @(negedge clk);
        end
        check("hold_no_rd", hits, 0);
        flag_z    = 1'b0;
        exec_done = 1'b1;
        next_fetch(a); check("hold_next", a, 2);
        check("hold_valid_clr", instr_valid, 0);
        exec_done = 1'b0;
        count_rd(8, hits);
        check("hold_one_fetch", hits, 0);
        exec_done = 1'b1;
        rom[1] = '0;

        // JMP to 0x1FFF, wrap to 0, then reset in ISSUE
        rom[0]       = {8'h27, 10'h3FF};
        rom[13'h1FFF] = {8'hA5, 10'h2AB};
        do_reset();
        next_fetch(a); check("wrap_f0", a, 0);
        next_fetch(a); check("wrap_fmax", a, 13'h1FFF);
        next_fetch(a); check("wrap_f0b", a, 0);
        next_fetch(a); check("wrap_fmax2", a, 13'h1FFF);
        exec_done = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_valid", instr_valid, 1);
        check("mid_pc", pc, 13'h1FFF);
        check("mid_fields", {OPCODE, K}, {8'hA5, 8'hAB});
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", instr_valid, 0);
        check("mid_rst_fields", {OPCODE, Ri, Rj, K}, 0);
        check("mid_rst_pc", pc, 0);
        check("mid_rst_addr", rom_addr, 0);
        check("mid_rst_rd", rom_rd, 0);
        exec_done = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        next_fetch(a); check("post_rst_f0", a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
